// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned DataBits      = 8;
  localparam int unsigned FrameBits     = 10;
  localparam int unsigned DefaultClkDiv = 868;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy and drop-on-full reporting.
module uart_sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [Width-1:0]        wdata_i,
  output logic [Width-1:0]        rdata_o,
  output logic [$clog2(Depth):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot a same-cycle push lands in, so full+pop+push is not a drop.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q + LvlW'(do_push) - LvlW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by single-cycle byte strobes.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth  = 16,
  parameter int unsigned ClkDiv = DefaultClkDiv,
  parameter int unsigned DropW  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             char_in_i,
  input  logic                   char_valid_i,
  input  logic                   clr_ovf_i,
  output logic                   txd_o,
  output logic                   busy_o,
  output logic                   fifo_full_o,
  output logic                   fifo_empty_o,
  output logic [$clog2(Depth):0] fifo_level_o,
  output logic                   overflow_o,
  output logic [DropW-1:0]       drop_cnt_o
);

  localparam int unsigned BaudW = $clog2(ClkDiv);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ovf_q, ovf_d;
  logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
  logic             pop, drop, baud_last;
  logic [7:0]       head;

  uart_sync_fifo #(
    .Depth (Depth),
    .Width (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (char_valid_i),
    .pop_i   (pop),
    .wdata_i (char_in_i),
    .rdata_o (head),
    .level_o (fifo_level_o),
    .full_o  (fifo_full_o),
    .empty_o (fifo_empty_o),
    .drop_o  (drop)
  );

  assign baud_last = (baud_q == BaudW'(ClkDiv - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BaudW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty_o) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'(DataBits - 1)) state_d = StStop;
          else                           bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty_o) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    if (state_d == StStart)     txd_d = 1'b0;
    else if (state_d == StData) txd_d = shift_d[0];
  end

  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      ovf_d      = 1'b1;
      drop_cnt_d = clr_ovf_i ? DropW'(1) :
                   (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + DropW'(1);
    end else if (clr_ovf_i) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign txd_o      = txd_q;
  assign busy_o     = (state_q != StIdle);
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-and-frame-counter model.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int unsigned Depth    = 4;
  localparam int unsigned Cd       = 4;
  localparam int unsigned DropW    = 8;
  localparam int          FrameCyc = FrameBits * Cd;
  localparam int          DropMax  = (1 << DropW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       txd, busy, fifo_full, fifo_empty, overflow;
  logic [$clog2(Depth):0] fifo_level;
  logic [DropW-1:0]       drop_cnt;

  uart_tx_fifo #(
    .Depth  (Depth),
    .ClkDiv (Cd),
    .DropW  (DropW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .char_in_i    (char_in),
    .char_valid_i (char_valid),
    .clr_ovf_i    (clr_ovf),
    .txd_o        (txd),
    .busy_o       (busy),
    .fifo_full_o  (fifo_full),
    .fifo_empty_o (fifo_empty),
    .fifo_level_o (fifo_level),
    .overflow_o   (overflow),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: byte queue plus "which cycle of the current frame" counter.
  logic [7:0] mq[$];
  logic       m_busy = 1'b0;
  int         m_cnt  = 0;
  logic [7:0] m_byte = '0;
  logic       m_ovf  = 1'b0;
  int         m_drop = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_cnt / Cd;
    if (k == 0) return 1'b0;
    if (k <= DataBits) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic step();
    bit pop, drop;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      pop  = (mq.size() != 0) && (!m_busy || m_cnt == FrameCyc - 1);
      drop = char_valid && (mq.size() == Depth) && !pop;
      if (m_busy) begin
        if (m_cnt == FrameCyc - 1) m_busy = 1'b0;
        else m_cnt++;
      end
      if (pop) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
        m_cnt  = 0;
      end
      if (char_valid && !drop) mq.push_back(char_in);
      if (drop) begin
        m_ovf  = 1'b1;
        m_drop = clr_ovf ? 1 : (m_drop == DropMax ? DropMax : m_drop + 1);
      end else if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
    #1;
    check_val("txd",      32'(txd),        32'(exp_txd()));
    check_val("busy",     32'(busy),       32'(m_busy));
    check_val("level",    32'(fifo_level), 32'(mq.size()));
    check_val("full",     32'(fifo_full),  32'(mq.size() == Depth));
    check_val("empty",    32'(fifo_empty), 32'(mq.size() == 0));
    check_val("overflow", 32'(overflow),   32'(m_ovf));
    check_val("drop_cnt", 32'(drop_cnt),   32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    char_in    = b;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  initial begin
    int tries;
    // Reset state
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single frame, then two back-to-back frames
    push_byte(8'h55);
    idle(45);
    push_byte(8'hA3);
    push_byte(8'h0F);
    idle(85);

    // Overflow by one with a frame in flight
    for (int i = 0; i < 6; i++) push_byte(8'(8'h30 + i));
    check_val("drop_after_burst", 32'(drop_cnt), 32'd1);
    check_val("ovf_after_burst", 32'(overflow), 32'd1);

    // Push exactly on the last stop cycle while full
    tries = 0;
    while (!(m_busy && m_cnt == FrameCyc - 1 && mq.size() == Depth) && tries < 100) begin
      step();
      tries++;
    end
    check_val("stop_align_timeout", 32'(tries < 100), 32'd1);
    push_byte(8'h77);
    check_val("full_swap_level", 32'(fifo_level), 32'(Depth));
    check_val("full_swap_drop", 32'(drop_cnt), 32'd1);
    idle(230);

    // Reset mid-DATA with bytes queued, then recover
    push_byte(8'hFF);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    idle(10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_txd", 32'(txd), 32'd1);
    check_val("rst_empty", 32'(fifo_empty), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    push_byte(8'h01);
    idle(45);

    // Saturating drop counter, clear-vs-drop priority, plain clear
    char_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      char_in = 8'($urandom);
      step();
    end
    check_val("drop_sat", 32'(drop_cnt), 32'(DropMax));
    clr_ovf = 1'b1;
    step();
    char_valid = 1'b0;
    step();
    clr_ovf = 1'b0;
    check_val("clr_alone_ovf", 32'(overflow), 32'd0);
    check_val("clr_alone_cnt", 32'(drop_cnt), 32'd0);
    idle(200);

    // Random traffic with alternating light and heavy load
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct        = ((i / 500) % 2 != 0) ? 10 : 2;
      char_in    = 8'($urandom);
      char_valid = ($urandom_range(0, 99) < pct);
      clr_ovf    = ($urandom_range(0, 99) < 2);
      rst        = ($urandom_range(0, 399) == 0);
      step();
    end
    char_valid = 1'b0;
    clr_ovf    = 1'b0;
    rst        = 1'b0;
    idle(250);
    check_val("drained_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
